// File: rtl/life_pkg.sv
// Shared defaults and types for the Life grid host port.
// Grid geometry defaults match the engine; row index width is derived here.
package life_pkg;

  localparam int unsigned LifeWidth  = 8;
  localparam int unsigned LifeHeight = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StLoad = 2'd2
  } stream_state_t;

  // A one-row grid still needs a 1-bit index to keep port widths legal.
  function automatic int unsigned row_idx_width(input int unsigned height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/life_row_counter.sv
// Wrapping row counter: counts 0..Height-1 on inc_i and flags the last row.
// The wrap compares against Height-1 so non power-of-two heights work.
module life_row_counter
  import life_pkg::*;
#(
  parameter int unsigned Height = LifeHeight,
  localparam int unsigned RowW = row_idx_width(Height)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            inc_i,
  output logic [RowW-1:0] row_o,
  output logic            at_last_o
);

  localparam logic [RowW-1:0] LastRow = RowW'(Height - 1);

  logic [RowW-1:0] row_d, row_q;

  assign at_last_o = (row_q == LastRow);
  assign row_o     = row_q;

  always_comb begin
    row_d = row_q;
    if (inc_i) begin
      row_d = at_last_o ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/life_grid_stream.sv
// Host port for the Life engine: snapshots and streams the grid out row by row,
// and writes host rows into the engine while holding it frozen.
module life_grid_stream
  import life_pkg::*;
#(
  parameter int unsigned Width  = LifeWidth,
  parameter int unsigned Height = LifeHeight,
  localparam int unsigned RowW = row_idx_width(Height)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [Width*Height-1:0] grid_i,
  input  logic                    snap_req_i,
  output logic                    busy_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [Width-1:0]        tx_data_o,
  output logic [RowW-1:0]         tx_row_o,
  output logic                    tx_last_o,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic [Width-1:0]        rx_data_i,
  output logic                    load_we_o,
  output logic [RowW-1:0]         load_row_o,
  output logic [Width-1:0]        load_data_o,
  output logic                    load_done_o,
  output logic                    engine_hold_o
);

  stream_state_t           state_q;
  logic [Width*Height-1:0] snapshot_q;
  logic                    load_we_q;
  logic [RowW-1:0]         load_row_q;
  logic [Width-1:0]        load_data_q;
  logic                    load_done_q;

  logic            tx_fire, rx_fire;
  logic [RowW-1:0] tx_cnt, rx_cnt;
  logic            tx_at_last, rx_at_last;

  assign rx_ready_o = (state_q == StIdle) || (state_q == StLoad);
  assign tx_valid_o = (state_q == StSend);
  assign busy_o     = (state_q != StIdle);

  assign tx_fire = tx_valid_o && tx_ready_i;
  assign rx_fire = rx_valid_i && rx_ready_o;

  life_row_counter #(
    .Height(Height)
  ) u_tx_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (tx_fire),
    .row_o    (tx_cnt),
    .at_last_o(tx_at_last)
  );

  life_row_counter #(
    .Height(Height)
  ) u_rx_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_i    (rx_fire),
    .row_o    (rx_cnt),
    .at_last_o(rx_at_last)
  );

  // tx_cnt only moves on a transfer, so the selected row is stable under backpressure.
  assign tx_data_o = snapshot_q[tx_cnt*Width +: Width];
  assign tx_row_o  = tx_cnt;
  assign tx_last_o = tx_valid_o && tx_at_last;

  assign load_we_o     = load_we_q;
  assign load_row_o    = load_row_q;
  assign load_data_o   = load_data_q;
  assign load_done_o   = load_done_q;
  // load_we_q extends the hold over the final write, which lands after the return to idle.
  assign engine_hold_o = (state_q == StLoad) || load_we_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      snapshot_q  <= '0;
      load_we_q   <= 1'b0;
      load_row_q  <= '0;
      load_data_q <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_we_q   <= rx_fire;
      load_done_q <= rx_fire && rx_at_last;
      if (rx_fire) begin
        load_row_q  <= rx_cnt;
        load_data_q <= rx_data_i;
      end

      unique case (state_q)
        StIdle: begin
          // A load request beats a simultaneous snapshot request.
          if (rx_fire) begin
            state_q <= rx_at_last ? StIdle : StLoad;
          end else if (snap_req_i) begin
            snapshot_q <= grid_i;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (tx_fire && tx_at_last) begin
            state_q <= StIdle;
          end
        end
        StLoad: begin
          if (rx_fire && rx_at_last) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_life_grid_stream.sv
// Directed self-checking bench for life_grid_stream with the default 8x8 grid.
module tb_life_grid_stream;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [63:0] grid_i;
  logic        snap_req_i;
  logic        busy_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  tx_data_o;
  logic [2:0]  tx_row_o;
  logic        tx_last_o;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  rx_data_i;
  logic        load_we_o;
  logic [2:0]  load_row_o;
  logic [7:0]  load_data_o;
  logic        load_done_o;
  logic        engine_hold_o;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [7:0] exp_rows [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};

  always #5 clk_i = ~clk_i;

  life_grid_stream u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .grid_i       (grid_i),
    .snap_req_i   (snap_req_i),
    .busy_o       (busy_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .tx_data_o    (tx_data_o),
    .tx_row_o     (tx_row_o),
    .tx_last_o    (tx_last_o),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .rx_data_i    (rx_data_i),
    .load_we_o    (load_we_o),
    .load_row_o   (load_row_o),
    .load_data_o  (load_data_o),
    .load_done_o  (load_done_o),
    .engine_hold_o(engine_hold_o)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_value({tag, " busy"}, busy_o, 0);
    check_value({tag, " tx_valid"}, tx_valid_o, 0);
    check_value({tag, " tx_last"}, tx_last_o, 0);
    check_value({tag, " load_we"}, load_we_o, 0);
    check_value({tag, " load_done"}, load_done_o, 0);
    check_value({tag, " hold"}, engine_hold_o, 0);
    check_value({tag, " rx_ready"}, rx_ready_o, 1);
  endtask

  task automatic check_tx_row(input string tag, input int r);
    check_value({tag, " tx_valid"}, tx_valid_o, 1);
    check_value({tag, " tx_data"}, tx_data_o, exp_rows[r]);
    check_value({tag, " tx_row"}, tx_row_o, r);
    check_value({tag, " tx_last"}, tx_last_o, (r == 7));
  endtask

  initial begin
    rst_ni     = 1'b0;
    grid_i     = '0;
    snap_req_i = 1'b0;
    tx_ready_i = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;

    // Reset state, both during and after reset.
    #3;
    check_quiet("in_reset");
    check_value("in_reset tx_data", tx_data_o, 0);
    check_value("in_reset load_row", load_row_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_quiet("after_reset");

    // Plain readout with the host always ready.
    grid_i     = 64'h8142_2418_1824_4281;
    snap_req_i = 1'b1;
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    snap_req_i = 1'b0;
    for (int r = 0; r < 8; r++) begin
      check_tx_row("readout", r);
      check_value("readout busy", busy_o, 1);
      @(negedge clk_i);
    end
    check_value("readout end tx_valid", tx_valid_o, 0);
    check_value("readout end busy", busy_o, 0);
    @(negedge clk_i);
    check_value("no rerun tx_valid", tx_valid_o, 0);

    // Backpressure with the live grid changed under a frozen snapshot.
    snap_req_i = 1'b1;
    tx_ready_i = 1'b0;
    @(negedge clk_i);
    snap_req_i = 1'b0;
    grid_i     = 64'hDEAD_BEEF_0123_4567;
    for (int r = 0; r < 8; r++) begin
      check_tx_row("bp_first", r);
      tx_ready_i = 1'b0;
      @(negedge clk_i);
      check_tx_row("bp_stalled", r);
      tx_ready_i = 1'b1;
      @(negedge clk_i);
    end
    tx_ready_i = 1'b0;
    check_value("bp end tx_valid", tx_valid_o, 0);
    check_value("bp end busy", busy_o, 0);

    // Full load, one row per cycle.
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h01;
    check_value("load rx_ready", rx_ready_o, 1);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk_i);
      check_value("load we", load_we_o, 1);
      check_value("load row", load_row_o, r);
      check_value("load data", load_data_o, 8'h01 << r);
      check_value("load done", load_done_o, (r == 7));
      check_value("load hold", engine_hold_o, 1);
      check_value("load busy", busy_o, (r != 7));
      check_value("load tx_valid", tx_valid_o, 0);
      if (r < 7) rx_data_i = 8'h01 << (r + 1);
      else rx_valid_i = 1'b0;
    end
    @(negedge clk_i);
    check_quiet("load_end");

    // Simultaneous snapshot and load request: the load wins.
    snap_req_i = 1'b1;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hFF;
    @(negedge clk_i);
    snap_req_i = 1'b0;
    check_value("collide we", load_we_o, 1);
    check_value("collide row", load_row_o, 0);
    check_value("collide data", load_data_o, 8'hFF);
    check_value("collide busy", busy_o, 1);
    check_value("collide tx_valid", tx_valid_o, 0);

    // Two more rows make a three-row partial load that then stalls.
    rx_data_i = 8'h5A;
    @(negedge clk_i);
    check_value("partial row1", load_row_o, 1);
    rx_data_i = 8'hA5;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    check_value("partial row2", load_row_o, 2);
    check_value("partial data2", load_data_o, 8'hA5);
    repeat (3) @(negedge clk_i);
    check_value("partial stall hold", engine_hold_o, 1);
    check_value("partial stall we", load_we_o, 0);
    check_value("partial stall tx_valid", tx_valid_o, 0);
    check_value("partial stall busy", busy_o, 1);

    // Mid-cycle reset abandons the load immediately.
    #2;
    rst_ni = 1'b0;
    #1;
    check_quiet("mid_reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h3C;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    check_value("restart we", load_we_o, 1);
    check_value("restart row", load_row_o, 0);
    check_value("restart data", load_data_o, 8'h3C);
    check_value("restart done", load_done_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
